// File: rtl/board_stabilizer.sv
// board_stabilizer: vsync-sampled board debouncer publishing stable boards; BOARD_STAB_CELLCOUNT_EN adds cell counting
module board_stabilizer #(
  parameter int STABLE_FRAMES = 3,
  parameter int ROWS = 18,
  parameter int COLS = 10,
  parameter int EXTRA = 8,
  parameter int W = ROWS * COLS + EXTRA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vsync,
  input  logic [W-1:0] board_in,
  output logic [W-1:0] board_out,
  output logic         board_valid,
  output logic [7:0]   cell_count,
  output logic         piece_spawn
);
  typedef enum logic [1:0] {IDLE, CHECK, COUNT, PUBLISH} state_t;
  state_t st_q, st_d;
  logic [2:0] sync_q, sync_d;
  logic [W-1:0] cur_q, cur_d, prev_q, prev_d, bo_q, bo_d;
  logic [3:0] mc_q, mc_d, mn;
  logic bv_q, bv_d, ps_q, ps_d, tick, go;
  assign tick = sync_q[1] & ~sync_q[2];
  assign board_out = bo_q;
  assign board_valid = bv_q;
  assign piece_spawn = ps_q;
`ifdef BOARD_STAB_CELLCOUNT_EN
  logic [4:0] ri_q, ri_d;
  logic [7:0] acc_q, acc_d, cc_q, cc_d;
  logic [COLS-1:0] row;
  assign cell_count = cc_q;
  function automatic logic [3:0] popcount(input logic [COLS-1:0] r);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < COLS; i++) p = p + 4'(r[i]);
    return p;
  endfunction
`else
  assign cell_count = '0;
`endif
  always_comb begin
    sync_d = {sync_q[1:0], vsync};
    st_d = st_q;
    cur_d = cur_q;
    prev_d = prev_q;
    bo_d = bo_q;
    mc_d = mc_q;
    bv_d = 1'b0;
    ps_d = 1'b0;
    mn = (cur_q == prev_q) ? ((mc_q >= 4'(STABLE_FRAMES)) ? 4'(STABLE_FRAMES) : mc_q + 4'd1) : 4'd1;
    go = (mn == 4'(STABLE_FRAMES)) && (cur_q != bo_q);
`ifdef BOARD_STAB_CELLCOUNT_EN
    ri_d = ri_q;
    acc_d = acc_q;
    cc_d = cc_q;
    row = cur_q[ri_q * COLS +: COLS];
`endif
    case (st_q)
      IDLE: begin
        cur_d = tick ? board_in : cur_q;
        st_d = tick ? CHECK : IDLE;
      end
      CHECK: begin
        mc_d = mn;
        prev_d = cur_q;
`ifdef BOARD_STAB_CELLCOUNT_EN
        ri_d = '0;
        acc_d = '0;
        st_d = go ? COUNT : IDLE;
`else
        st_d = go ? PUBLISH : IDLE;
`endif
      end
`ifdef BOARD_STAB_CELLCOUNT_EN
      COUNT: begin
        acc_d = acc_q + 8'(popcount(row));
        ri_d = ri_q + 5'd1;
        st_d = (ri_q == 5'(ROWS - 1)) ? PUBLISH : COUNT;
      end
`endif
      PUBLISH: begin
        bo_d = cur_q;
        bv_d = 1'b1;
        ps_d = ~|bo_q[2*COLS-1:0] & |cur_q[2*COLS-1:0];
`ifdef BOARD_STAB_CELLCOUNT_EN
        cc_d = acc_q;
`endif
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      sync_q <= '0;
      cur_q <= '0;
      prev_q <= '0;
      bo_q <= '0;
      mc_q <= '0;
      bv_q <= 1'b0;
      ps_q <= 1'b0;
`ifdef BOARD_STAB_CELLCOUNT_EN
      ri_q <= '0;
      acc_q <= '0;
      cc_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      sync_q <= sync_d;
      cur_q <= cur_d;
      prev_q <= prev_d;
      bo_q <= bo_d;
      mc_q <= mc_d;
      bv_q <= bv_d;
      ps_q <= ps_d;
`ifdef BOARD_STAB_CELLCOUNT_EN
      ri_q <= ri_d;
      acc_q <= acc_d;
      cc_q <= cc_d;
`endif
    end
  end
endmodule

// File: tb/tb_board_stabilizer.sv
// tb_board_stabilizer: scoreboard bench for board_stabilizer publish timing, counts and spawn flag
module tb_board_stabilizer;
  localparam int W = 188;
`ifdef BOARD_STAB_CELLCOUNT_EN
  localparam int LAT = 23;
  localparam bit CC = 1'b1;
`else
  localparam int LAT = 5;
  localparam bit CC = 1'b0;
`endif
  localparam logic [W-1:0] A = 188'h3FF << 170;
  localparam logic [W-1:0] X = 188'h1 << 100;
  localparam logic [W-1:0] Y = 188'h3 << 100;
  localparam logic [W-1:0] S = A | 188'h30;
  localparam logic [W-1:0] E = S | (188'h1 << 187);
  localparam logic [W-1:0] R = A | 188'h3C00;
  typedef struct {
    logic [W-1:0] b;
    logic [7:0] c;
    logic s;
    int t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0;
  logic [W-1:0] board_in = '0, board_out;
  logic board_valid, piece_spawn, prev_bv = 1'b0;
  logic [7:0] cell_count;
  int cyc = 0, checks = 0, fails = 0, pubs = 0;
  exp_t q[$];
  board_stabilizer dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .board_in(board_in),
    .board_out(board_out), .board_valid(board_valid),
    .cell_count(cell_count), .piece_spawn(piece_spawn)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && board_valid) begin
      exp_t e;
      pubs++;
      chk("pulse_width", W'(prev_bv), W'(0));
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("board_out", board_out, e.b);
        chk("cell_count", W'(cell_count), W'(e.c));
        chk("piece_spawn", W'(piece_spawn), W'(e.s));
        chk("latency", W'(cyc), W'(e.t));
      end
    end
    prev_bv <= board_valid;
  end
  task automatic frame(input logic [W-1:0] b, input bit pub, input logic [7:0] c, input bit s);
    @(negedge clk);
    board_in = b;
    vsync = 1'b1;
    if (pub) q.push_back('{b, CC ? c : 8'd0, s, cyc + LAT});
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (36) @(negedge clk);
  endtask
  task automatic zero_outs(input string tag);
    chk({tag, "_board_out"}, board_out, '0);
    chk({tag, "_cell_count"}, W'(cell_count), '0);
    chk({tag, "_valid"}, W'(board_valid), '0);
    chk({tag, "_spawn"}, W'(piece_spawn), '0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    zero_outs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame(A, 0, 0, 0);
    frame(A, 0, 0, 0);
    frame(A, 1, 10, 0);
    frame(A, 0, 0, 0);
    frame(A, 0, 0, 0);
    for (int i = 0; i < 6; i++) frame(i[0] ? Y : X, 0, 0, 0);
    chk("flicker_hold", board_out, A);
    frame(S, 0, 0, 0);
    frame(S, 0, 0, 0);
    frame(S, 1, 12, 1);
    frame(E, 0, 0, 0);
    frame(E, 0, 0, 0);
    frame(E, 1, 12, 0);
    frame(R, 0, 0, 0);
    frame(R, 0, 0, 0);
    @(negedge clk);
    board_in = R;
    vsync = 1'b1;
    if (LAT < 13) q.push_back('{R, 8'd0, 1'b0, cyc + LAT});
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    zero_outs("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (36) @(negedge clk);
    zero_outs("post_reset");
    frame(R, 0, 0, 0);
    frame(R, 0, 0, 0);
    frame(R, 1, 14, 1);
    frame(R, 0, 0, 0);
    chk("queue_drained", W'(q.size()), '0);
    chk("publish_total", W'(pubs), W'(LAT < 13 ? 5 : 4));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
